rr_arbiter_4: RTL and testbench
===============================

// Module: rr_arbiter_4
// PURPOSE
//  Round-robin arbiter sharing one resource among 4 requesters. Drives the
//  2-to-4 decoder (x/en inputs) that fans the select out to the resource
//  enables. Owns the sequencing: pick, hold, time-out, turnaround gap.
// PARAMETERS
//  CNT_W       8   width of the hold and gap counters
//  MAX_HOLD    16  max consecutive grant cycles per tenure (1..2^CNT_W-1)
//  GAP_CYCLES  1   idle cycles after a tenure ends (0..2^CNT_W-1; 0 = none)
// PORTS
//  clk      in   1  system clock; all logic on rising edge
//  reset    in   1  synchronous, active-high reset
//  req      in   4  req[i]=1: requester i wants the resource; level, held
//  gnt      out  4  one-hot grant; gnt[i]=1: requester i owns the resource
//  sel      out  2  decoder x input; sel = ~idx, so decoder y[i] == gnt[i]
//  en       out  1  decoder enable; 1 exactly when gnt != 0
//  busy     out  1  1 in BUSY or GAP state
//  timeout  out  1  one-cycle pulse: tenure ended by MAX_HOLD
// BEHAVIOUR
//  - One clock and one reset. Reset is synchronous and active-high. All
//    outputs are registered.
//  - Reset values: gnt=0, en=0, busy=0, timeout=0, idx=0 (so sel=2'b11),
//    last=3 (requester 0 has top priority after reset), state=IDLE, counters=0.
//  - reset=1 mid-tenure: all of the above apply on the next edge. The grant
//    drops that cycle. No timeout pulse.
//  - Priority: search order is last+1, last+2, last+3, last (mod 4). The first
//    set req bit wins.
//  - States:
//    IDLE: if req!=0, take winner w. Next cycle: gnt=1<<w, idx=w, en=1,
//      busy=1, hold_cnt=1, last=w, go BUSY. Latency req->gnt is 1 cycle.
//    BUSY: if req[idx]==0, the grant drops next cycle.
//      If req[idx]==1 and hold_cnt==MAX_HOLD, the grant drops next cycle and
//      timeout=1 for that one cycle.
//      Otherwise hold_cnt increments and the grant holds.
//      On drop: gnt=0, en=0, idx keeps its value (sel static). Go to GAP if
//      GAP_CYCLES>0 (gap_cnt=1), else go to IDLE.
//    GAP: busy=1, gnt=0. When gap_cnt==GAP_CYCLES go to IDLE, else increment.
//  - A grant is never shown for the whole of MAX_HOLD+1 consecutive cycles.
//  - Max visible grant cycles per tenure = MAX_HOLD.
//  - Back-to-back: with GAP_CYCLES=0, the grant is low for exactly 1 cycle
//    (the IDLE arbitration cycle) between tenures.
//  - A timed-out requester keeps its req high: it is re-arbitrated at lowest
//    priority (last=its index), so it cannot starve the others.
//  - Requests that appear or vanish during BUSY/GAP are only sampled in IDLE.
//    The exception is req[idx] in BUSY.
//  - Counters saturate, never wrap: parameter checks reject MAX_HOLD=0 and
//    values beyond the range given in PARAMETERS.
//  - gnt is always one-hot or zero. en == |gnt. sel == ~idx every cycle.
// TESTING
//  T1 reset: hold reset 3 cycles with req=4'b1111 -> gnt=0, en=0, sel=2'b11,
//     busy=0. First grant after release is gnt=4'b0001.
//  T2 rotation: req=4'b1111 steady, MAX_HOLD=4, GAP=1 -> gnt sequence
//     0001,0010,0100,1000,0001.
//     Each grant lasts 4 cycles with timeout pulses; 2 low cycles between
//     grants (GAP + IDLE).
//  T3 early release: req=4'b0100 for 3 cycles then 0 -> gnt=4'b0100 for 3
//     cycles starting 1 cycle after req. No timeout. busy low 2 cycles after
//     the drop.
//  T4 decoder tie-in: instantiate the 2-to-4 decoder on sel/en. Each cycle
//     check y==gnt. For a lone req[3], sel=2'b00 and y=4'b1000.
//  T5 reset mid-tenure: reset=1 at hold_cnt=2 of a grant to 2 -> next cycle
//     gnt=0, timeout=0. After release with req=4'b0110, the grant goes to
//     requester 1.
//  T6 GAP_CYCLES=0, req=4'b0011 held, MAX_HOLD=2 -> gnt 0001 x2, 0 x1,
//     0010 x2, 0 x1, 0001.

Source files
------------

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the four requesters and the round-robin arbiter.
// The slave modport is the arbiter side; master is the requester side.
`timescale 1ns/1ps
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       en;
  logic       busy;
  logic       timeout;

  modport master (output req, input gnt, sel, en, busy, timeout);
  modport slave  (input req, output gnt, sel, en, busy, timeout);
endinterface

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with bounded tenure and turnaround gap.
// sel/en feed a 2-to-4 decoder whose outputs mirror gnt.
`timescale 1ns/1ps
module rr_arbiter_4 #(
  parameter int CNT_W      = 8,
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  rr_arbiter_4_if.slave bus
);

  generate
    if ((MAX_HOLD < 1) || (MAX_HOLD > (2 ** CNT_W) - 1)) begin : g_bad_max_hold
      $error("rr_arbiter_4: MAX_HOLD out of range");
    end
    if ((GAP_CYCLES < 0) || (GAP_CYCLES > (2 ** CNT_W) - 1)) begin : g_bad_gap
      $error("rr_arbiter_4: GAP_CYCLES out of range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t           state;
  logic [3:0]       gnt_q;
  logic [1:0]       sel_q;
  logic             en_q;
  logic             busy_q;
  logic             timeout_q;
  logic [1:0]       idx;
  logic [1:0]       last;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] gap_cnt;

  logic [1:0] win;
  logic [1:0] cand;
  logic       found;

  // Search starts just after the previous winner; k=4 wraps back to last itself.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '1;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      idx       <= '0;
      last      <= 2'd3;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt_q    <= 4'b0001 << win;
            idx      <= win;
            sel_q    <= ~win;
            en_q     <= 1'b1;
            busy_q   <= 1'b1;
            hold_cnt <= CNT_W'(1);
            last     <= win;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!bus.req[idx] || (hold_cnt == MAX_C)) begin
            gnt_q     <= '0;
            en_q      <= 1'b0;
            timeout_q <= bus.req[idx];
            hold_cnt  <= '0;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= CNT_W'(1);
              state   <= GAP;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_C) begin
            gap_cnt <= '0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.en      = en_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: two instances (MAX_HOLD=4/GAP=1 and
// MAX_HOLD=2/GAP=0) with a behavioural 2-to-4 decoder on each sel/en pair.
`timescale 1ns/1ps
module tb_rr_arbiter_4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rr_arbiter_4_if a_if();
  rr_arbiter_4_if b_if();

  rr_arbiter_4 #(.CNT_W(8), .MAX_HOLD(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave));
  rr_arbiter_4 #(.CNT_W(8), .MAX_HOLD(2), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave));

  // 2-to-4 decoder: output y[3-x] when enabled.
  logic [3:0] a_y, b_y;
  always_comb a_y = a_if.en ? (4'b1000 >> a_if.sel) : 4'b0000;
  always_comb b_y = b_if.en ? (4'b1000 >> b_if.sel) : 4'b0000;

  typedef struct packed { logic rst; logic [3:0] req; } stim_t;
  typedef struct packed { logic [3:0] gnt; logic [1:0] sel; logic busy; logic to; } exp_t;

  stim_t sq[$];
  exp_t  eq[$];
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rst, input logic [3:0] rq, input logic [3:0] g,
                      input logic [1:0] s, input logic b, input logic t);
    stim_t st;
    exp_t  ex;
    st = '{rst: rst, req: rq};
    ex = '{gnt: g, sel: s, busy: b, to: t};
    sq.push_back(st);
    eq.push_back(ex);
  endtask

  task automatic test_reset();
    stim_t s; exp_t e; int n;
    n = 0;
    for (int i = 0; i < 3; i++) push(1'b1, 4'b1111, 4'b0000, 2'b11, 1'b0, 1'b0);
    push(1'b0, 4'b1111, 4'b0001, 2'b11, 1'b1, 1'b0);
    while (eq.size() > 0) begin
      s = sq.pop_front(); reset = s.rst; a_if.req = s.req;
      tick(); e = eq.pop_front(); n++;
      checks++; if (a_if.gnt !== e.gnt) begin errors++; $display("FAIL reset_gnt cyc%0d got %b want %b", n, a_if.gnt, e.gnt); end
      checks++; if (a_if.sel !== e.sel) begin errors++; $display("FAIL reset_sel cyc%0d got %b want %b", n, a_if.sel, e.sel); end
      checks++; if (a_if.busy !== e.busy) begin errors++; $display("FAIL reset_busy cyc%0d got %b want %b", n, a_if.busy, e.busy); end
      checks++; if (a_if.timeout !== e.to) begin errors++; $display("FAIL reset_timeout cyc%0d got %b want %b", n, a_if.timeout, e.to); end
      checks++; if (a_if.en !== (|e.gnt)) begin errors++; $display("FAIL reset_en cyc%0d got %b want %b", n, a_if.en, |e.gnt); end
      checks++; if (a_y !== e.gnt) begin errors++; $display("FAIL reset_dec cyc%0d got %b want %b", n, a_y, e.gnt); end
    end
  endtask

  task automatic test_rotation();
    stim_t s; exp_t e; int n; logic [1:0] tt;
    n = 0;
    push(1'b1, 4'b1111, 4'b0000, 2'b11, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      tt = 2'(t);
      for (int h = 0; h < 4; h++) push(1'b0, 4'b1111, 4'b0001 << tt, ~tt, 1'b1, 1'b0);
      push(1'b0, 4'b1111, 4'b0000, ~tt, 1'b1, 1'b1);
      push(1'b0, 4'b1111, 4'b0000, ~tt, 1'b0, 1'b0);
    end
    push(1'b0, 4'b1111, 4'b0001, 2'b11, 1'b1, 1'b0);
    while (eq.size() > 0) begin
      s = sq.pop_front(); reset = s.rst; a_if.req = s.req;
      tick(); e = eq.pop_front(); n++;
      checks++; if (a_if.gnt !== e.gnt) begin errors++; $display("FAIL rot_gnt cyc%0d got %b want %b", n, a_if.gnt, e.gnt); end
      checks++; if (a_if.sel !== e.sel) begin errors++; $display("FAIL rot_sel cyc%0d got %b want %b", n, a_if.sel, e.sel); end
      checks++; if (a_if.busy !== e.busy) begin errors++; $display("FAIL rot_busy cyc%0d got %b want %b", n, a_if.busy, e.busy); end
      checks++; if (a_if.timeout !== e.to) begin errors++; $display("FAIL rot_timeout cyc%0d got %b want %b", n, a_if.timeout, e.to); end
      checks++; if (a_if.en !== (|e.gnt)) begin errors++; $display("FAIL rot_en cyc%0d got %b want %b", n, a_if.en, |e.gnt); end
      checks++; if (a_y !== e.gnt) begin errors++; $display("FAIL rot_dec cyc%0d got %b want %b", n, a_y, e.gnt); end
    end
  endtask

  task automatic test_early_release();
    stim_t s; exp_t e; int n;
    n = 0;
    push(1'b1, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(1'b0, 4'b0100, 4'b0100, 2'b01, 1'b1, 1'b0);
    push(1'b0, 4'b0000, 4'b0000, 2'b01, 1'b1, 1'b0);
    push(1'b0, 4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0);
    push(1'b0, 4'b0000, 4'b0000, 2'b01, 1'b0, 1'b0);
    while (eq.size() > 0) begin
      s = sq.pop_front(); reset = s.rst; a_if.req = s.req;
      tick(); e = eq.pop_front(); n++;
      checks++; if (a_if.gnt !== e.gnt) begin errors++; $display("FAIL early_gnt cyc%0d got %b want %b", n, a_if.gnt, e.gnt); end
      checks++; if (a_if.sel !== e.sel) begin errors++; $display("FAIL early_sel cyc%0d got %b want %b", n, a_if.sel, e.sel); end
      checks++; if (a_if.busy !== e.busy) begin errors++; $display("FAIL early_busy cyc%0d got %b want %b", n, a_if.busy, e.busy); end
      checks++; if (a_if.timeout !== e.to) begin errors++; $display("FAIL early_timeout cyc%0d got %b want %b", n, a_if.timeout, e.to); end
      checks++; if (a_if.en !== (|e.gnt)) begin errors++; $display("FAIL early_en cyc%0d got %b want %b", n, a_if.en, |e.gnt); end
      checks++; if (a_y !== e.gnt) begin errors++; $display("FAIL early_dec cyc%0d got %b want %b", n, a_y, e.gnt); end
    end
  endtask

  task automatic test_decoder();
    stim_t s; exp_t e; int n;
    n = 0;
    push(1'b1, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) push(1'b0, 4'b1000, 4'b1000, 2'b00, 1'b1, 1'b0);
    push(1'b0, 4'b1000, 4'b0000, 2'b00, 1'b1, 1'b1);
    push(1'b0, 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b0);
    push(1'b0, 4'b1000, 4'b1000, 2'b00, 1'b1, 1'b0);
    while (eq.size() > 0) begin
      s = sq.pop_front(); reset = s.rst; a_if.req = s.req;
      tick(); e = eq.pop_front(); n++;
      checks++; if (a_if.gnt !== e.gnt) begin errors++; $display("FAIL dec_gnt cyc%0d got %b want %b", n, a_if.gnt, e.gnt); end
      checks++; if (a_if.sel !== e.sel) begin errors++; $display("FAIL dec_sel cyc%0d got %b want %b", n, a_if.sel, e.sel); end
      checks++; if (a_if.busy !== e.busy) begin errors++; $display("FAIL dec_busy cyc%0d got %b want %b", n, a_if.busy, e.busy); end
      checks++; if (a_if.timeout !== e.to) begin errors++; $display("FAIL dec_timeout cyc%0d got %b want %b", n, a_if.timeout, e.to); end
      checks++; if (a_if.en !== (|e.gnt)) begin errors++; $display("FAIL dec_en cyc%0d got %b want %b", n, a_if.en, |e.gnt); end
      checks++; if (a_y !== e.gnt) begin errors++; $display("FAIL dec_y cyc%0d got %b want %b", n, a_y, e.gnt); end
    end
  endtask

  task automatic test_reset_mid_tenure();
    stim_t s; exp_t e; int n;
    n = 0;
    push(1'b1, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0);
    push(1'b0, 4'b0100, 4'b0100, 2'b01, 1'b1, 1'b0);
    push(1'b0, 4'b0100, 4'b0100, 2'b01, 1'b1, 1'b0);
    push(1'b1, 4'b0100, 4'b0000, 2'b11, 1'b0, 1'b0);
    push(1'b0, 4'b0110, 4'b0010, 2'b10, 1'b1, 1'b0);
    push(1'b0, 4'b0110, 4'b0010, 2'b10, 1'b1, 1'b0);
    while (eq.size() > 0) begin
      s = sq.pop_front(); reset = s.rst; a_if.req = s.req;
      tick(); e = eq.pop_front(); n++;
      checks++; if (a_if.gnt !== e.gnt) begin errors++; $display("FAIL midrst_gnt cyc%0d got %b want %b", n, a_if.gnt, e.gnt); end
      checks++; if (a_if.sel !== e.sel) begin errors++; $display("FAIL midrst_sel cyc%0d got %b want %b", n, a_if.sel, e.sel); end
      checks++; if (a_if.busy !== e.busy) begin errors++; $display("FAIL midrst_busy cyc%0d got %b want %b", n, a_if.busy, e.busy); end
      checks++; if (a_if.timeout !== e.to) begin errors++; $display("FAIL midrst_timeout cyc%0d got %b want %b", n, a_if.timeout, e.to); end
      checks++; if (a_if.en !== (|e.gnt)) begin errors++; $display("FAIL midrst_en cyc%0d got %b want %b", n, a_if.en, |e.gnt); end
      checks++; if (a_y !== e.gnt) begin errors++; $display("FAIL midrst_dec cyc%0d got %b want %b", n, a_y, e.gnt); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s; exp_t e; int n;
    n = 0;
    a_if.req = 4'b0000;
    push(1'b1, 4'b0011, 4'b0000, 2'b11, 1'b0, 1'b0);
    push(1'b0, 4'b0011, 4'b0001, 2'b11, 1'b1, 1'b0);
    push(1'b0, 4'b0011, 4'b0001, 2'b11, 1'b1, 1'b0);
    push(1'b0, 4'b0011, 4'b0000, 2'b11, 1'b0, 1'b1);
    push(1'b0, 4'b0011, 4'b0010, 2'b10, 1'b1, 1'b0);
    push(1'b0, 4'b0011, 4'b0010, 2'b10, 1'b1, 1'b0);
    push(1'b0, 4'b0011, 4'b0000, 2'b10, 1'b0, 1'b1);
    push(1'b0, 4'b0011, 4'b0001, 2'b11, 1'b1, 1'b0);
    while (eq.size() > 0) begin
      s = sq.pop_front(); reset = s.rst; b_if.req = s.req;
      tick(); e = eq.pop_front(); n++;
      checks++; if (b_if.gnt !== e.gnt) begin errors++; $display("FAIL b2b_gnt cyc%0d got %b want %b", n, b_if.gnt, e.gnt); end
      checks++; if (b_if.sel !== e.sel) begin errors++; $display("FAIL b2b_sel cyc%0d got %b want %b", n, b_if.sel, e.sel); end
      checks++; if (b_if.busy !== e.busy) begin errors++; $display("FAIL b2b_busy cyc%0d got %b want %b", n, b_if.busy, e.busy); end
      checks++; if (b_if.timeout !== e.to) begin errors++; $display("FAIL b2b_timeout cyc%0d got %b want %b", n, b_if.timeout, e.to); end
      checks++; if (b_if.en !== (|e.gnt)) begin errors++; $display("FAIL b2b_en cyc%0d got %b want %b", n, b_if.en, |e.gnt); end
      checks++; if (b_y !== e.gnt) begin errors++; $display("FAIL b2b_dec cyc%0d got %b want %b", n, b_y, e.gnt); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.req = 4'b0000;
    b_if.req = 4'b0000;
    reset = 1'b1;
    test_reset();
    test_rotation();
    test_early_release();
    test_decoder();
    test_reset_mid_tenure();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
